// File: rtl/axi_demo_lite_responder.sv
// AXI4-Lite subordinate backed by a bank of 32-bit control registers.
// Define AXIDEMO_ADDR_ERR_EN to answer out-of-range accesses with SLVERR.
module axi_demo_lite_responder #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDXW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    RESP
  } wrState_e;

  wrState_e state;
  wrState_e nextState;

  logic [DATA_WIDTH-1:0] regFile [NUM_REGS];
  logic [ADDR_WIDTH-1:0] awAddrQ;
  logic [DATA_WIDTH-1:0] wDataQ;
  logic [STRB_WIDTH-1:0] wStrbQ;

  logic                  awHs;
  logic                  wHs;
  logic                  arHs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] cAddr;
  logic [DATA_WIDTH-1:0] cData;
  logic [STRB_WIDTH-1:0] cStrb;
  logic [IDXW-1:0]       cIdx;
  logic [IDXW-1:0]       rIdx;
  logic                  cOk;
  logic                  rOk;
  logic                  unusedAddr;

  assign awHs = awvalid & awready;
  assign wHs  = wvalid & wready;
  assign arHs = arvalid & arready;

  // The committing beat mixes latched and live channel payloads.
  assign cAddr = (state == HAVE_AW) ? awAddrQ : awaddr;
  assign cData = (state == HAVE_W) ? wDataQ : wdata;
  assign cStrb = (state == HAVE_W) ? wStrbQ : wstrb;
  assign cIdx  = cAddr[IDXW+1:2];
  assign rIdx  = araddr[IDXW+1:2];

`ifdef AXIDEMO_ADDR_ERR_EN
  assign cOk = (cAddr >> (IDXW + 2)) == '0;
  assign rOk = (araddr >> (IDXW + 2)) == '0;
`else
  assign cOk = 1'b1;
  assign rOk = 1'b1;
`endif

  assign unusedAddr = ^{cAddr, araddr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (awHs && wHs) begin
          nextState = RESP;
          commit    = 1'b1;
        end else if (awHs) begin
          nextState = HAVE_AW;
        end else if (wHs) begin
          nextState = HAVE_W;
        end
      end
      HAVE_AW: begin
        if (wHs) begin
          nextState = RESP;
          commit    = 1'b1;
        end
      end
      HAVE_W: begin
        if (awHs) begin
          nextState = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (bready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (state)
      IDLE: begin
        awready = !rst;
        wready  = !rst;
      end
      HAVE_AW: wready  = !rst;
      HAVE_W:  awready = !rst;
      RESP:    bvalid  = 1'b1;
      default: bvalid  = 1'b0;
    endcase
  end

  assign arready = !rst && !rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      awAddrQ <= '0;
      wDataQ  <= '0;
      wStrbQ  <= '0;
    end else begin
      if (awHs) begin
        awAddrQ <= awaddr;
      end
      if (wHs) begin
        wDataQ <= wdata;
        wStrbQ <= wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regFile[k] <= '0;
      end
      bresp <= 2'b00;
    end else if (commit) begin
      bresp <= cOk ? 2'b00 : 2'b10;
      if (cOk) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (cStrb[b]) begin
            regFile[cIdx][8*b +: 8] <= cData[8*b +: 8];
          end
        end
      end
    end
  end

  // Reads sample the bank before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (arHs) begin
      rvalid <= 1'b1;
      rdata  <= rOk ? regFile[rIdx] : '0;
      rresp  <= rOk ? 2'b00 : 2'b10;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regFile[k];
  end

endmodule

// File: tb/tb_axi_demo_lite_responder.sv
// Randomized bench for axi_demo_lite_responder against a register-array model.
// Honours AXIDEMO_ADDR_ERR_EN to select the expected out-of-range behaviour.
module tb_axi_demo_lite_responder;

  localparam int NR = 16;

`ifdef AXIDEMO_ADDR_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          awvalid, awready;
  logic [31:0]   awaddr;
  logic          wvalid, wready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [31:0]   araddr;
  logic          rvalid, rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic [NR*32-1:0] regsO;

  int nChecks = 0;
  int nErrors = 0;
  logic [31:0] model [NR];

  always #5 clk = ~clk;

  axi_demo_lite_responder #(
    .NUM_REGS(NR), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .regs_o(regsO)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit inRange(input logic [31:0] a);
    return a < NR * 4;
  endfunction

  function automatic int idxOf(input logic [31:0] a);
    return int'((a / 4) % NR);
  endfunction

  task automatic checkBank(input string tag);
    for (int k = 0; k < NR; k++) begin
      check(tag, regsO[k*32 +: 32], model[k]);
    end
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int gap,
                         input bit wFirst, input int holdB);
    bit awDone, wDone, awHs, wHs, ok;
    int cyc;
    logic [1:0] expResp;
    awDone = 0;
    wDone = 0;
    cyc = 0;
    ok = !(ERR && !inRange(a));
    expResp = ok ? 2'b00 : 2'b10;
    @(negedge clk);
    awaddr = a;
    wdata = d;
    wstrb = s;
    bready = (holdB == 0);
    if (gap == 0 || !wFirst) awvalid = 1'b1;
    if (gap == 0 || wFirst) wvalid = 1'b1;
    while (!(awDone && wDone) && cyc < 40) begin
      check("bvalidEarly", bvalid, 0);
      awHs = awvalid && awready;
      wHs = wvalid && wready;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (awHs) begin awDone = 1; awvalid = 1'b0; end
      if (wHs) begin wDone = 1; wvalid = 1'b0; end
      if (cyc == gap) begin
        if (!awDone) awvalid = 1'b1;
        if (!wDone) wvalid = 1'b1;
      end
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    check("wrTimeout", 32'(awDone && wDone), 1);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, expResp);
    if (ok) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[idxOf(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
    checkBank("regsO");
    for (int i = 0; i < holdB; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bHoldValid", bvalid, 1);
      check("bHoldAwready", awready, 0);
      check("bHoldWready", wready, 0);
      check("bHoldResp", bresp, expResp);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bDone", bvalid, 0);
  endtask

  task automatic doRead(input logic [31:0] a, input int holdR);
    logic [31:0] expData;
    logic [1:0] expResp;
    int cyc;
    bit done, hs;
    cyc = 0;
    done = 0;
    if (ERR && !inRange(a)) begin
      expData = 0;
      expResp = 2'b10;
    end else begin
      expData = model[idxOf(a)];
      expResp = 2'b00;
    end
    @(negedge clk);
    araddr = a;
    arvalid = 1'b1;
    rready = (holdR == 0);
    while (!done && cyc < 40) begin
      hs = arready;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (hs) begin done = 1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    check("rdTimeout", 32'(done), 1);
    check("rvalid", rvalid, 1);
    check("rdata", rdata, expData);
    check("rresp", rresp, expResp);
    for (int i = 0; i < holdR; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rHoldValid", rvalid, 1);
      check("rHoldArready", arready, 0);
      check("rHoldData", rdata, expData);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rDone", rvalid, 0);
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0;
    bready = 1; arvalid = 0; araddr = 0; rready = 1;
    for (int k = 0; k < NR; k++) model[k] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstAwready", awready, 0);
    check("rstWready", wready, 0);
    check("rstArready", arready, 0);
    rst = 1'b0;
    #1;
    check("postRstAwready", awready, 1);
    check("postRstWready", wready, 1);
    check("postRstArready", arready, 1);
    check("postRstBvalid", bvalid, 0);
    check("postRstRvalid", rvalid, 0);
    check("postRstRdata", rdata, 0);
    check("postRstBresp", bresp, 0);
    checkBank("postRstRegs");

    doWrite(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    doRead(32'h08, 0);
    doWrite(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    doWrite(32'h04, 32'h11223344, 4'h5, 3, 1, 0);
    check("reg1Merge", regsO[63:32], 32'hFF22FF44);
    doWrite(32'h14, 32'h0BADF00D, 4'hF, 2, 0, 5);
    doWrite(32'h14, 32'h12345678, 4'h0, 0, 0, 0);
    doRead(32'h14, 4);

    fork
      doWrite(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      begin
        check("sameEdgeOld", model[3], 0);
        doRead(32'h0C, 0);
      end
    join
    doRead(32'h0C, 0);

    doWrite(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    doRead(32'h40, 0);

    @(negedge clk);
    awaddr = 32'h10; awvalid = 1'b1;
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    check("preRstRvalid", rvalid, 1);
    check("preRstAwready", awready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NR; k++) model[k] = 0;
    check("midRstBvalid", bvalid, 0);
    check("midRstRvalid", rvalid, 0);
    check("midRstRdata", rdata, 0);
    check("midRstAwready", awready, 0);
    checkBank("midRstRegs");
    rst = 1'b0;
    rready = 1'b1;
    #1;
    check("midRstAwready1", awready, 1);
    check("midRstWready1", wready, 1);
    doWrite(32'h10, 32'h5A5A1234, 4'hF, 0, 0, 0);
    doRead(32'h10, 0);

    for (int i = 0; i < 40; i++) begin
      doWrite($urandom_range(0, NR * 8 - 1), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2));
      doRead($urandom_range(0, NR * 8 - 1), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/axi_demo_lite_responder.md
# axi_demo_lite_responder

AXI4-Lite subordinate that terminates the axiDemo address/data/strobe interface and backs it with a bank of 32-bit control registers. It accepts independent AW/W channels, applies byte strobes, returns B responses, and serves AR/R reads. It sits at the end of the axiDemo interconnect and exposes the register bank to the datapath as a flat output bus.

## Interface
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256
- ADDR_WIDTH, 32, address width (matches AXI_ADDRESS_WIDTH)
- DATA_WIDTH, 32, data width (matches AXI_DATA_WIDTH)
- STRB_WIDTH, 4, strobe width, DATA_WIDTH/8 (matches AXI_STROBE_WIDTH)
- clk  in  1  single clock for all logic
- rst  in  1  reset, synchronous, active-high
- awvalid / awready  in / out  1  write-address handshake
- awaddr  in  ADDR_WIDTH  byte write address
- wvalid / wready  in / out  1  write-data handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  STRB_WIDTH  byte enables; bit i enables wdata[8i+7:8i]
- bvalid / bready  out / in  1  write-response handshake
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- arvalid / arready  in / out  1  read-address handshake
- araddr  in  ADDR_WIDTH  byte read address
- rvalid / rready  out / in  1  read-data handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- regs_o  out  NUM_REGS*DATA_WIDTH  register bank; reg k at [k*32+31:k*32]

## Operation
- Word index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored (treated as aligned).
- In range: addr < NUM_REGS*4. Out-of-range handling is defined under Configuration.
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: awready=wready=1. AW-only handshake -> HAVE_AW (latch awaddr). W-only handshake -> HAVE_W (latch wdata, wstrb). Both in the same cycle -> commit -> RESP.
  - HAVE_AW: awready=0, wready=1; W handshake -> commit -> RESP.
  - HAVE_W: wready=0, awready=1; AW handshake -> commit -> RESP.
  - RESP: awready=wready=0, bvalid=1, bresp held stable; bready -> IDLE.
- Commit: per-byte update of the addressed register where the wstrb bit is 1. wstrb=0 is a legal no-op that returns OKAY.
- Read path: arready = !rvalid. On an AR handshake, rdata/rresp are registered and rvalid=1; these hold stable until rready, then rvalid=0.
- Read and write paths are independent and may complete in the same cycle.

## Timing
- Reset (rst=1 at an edge): all registers 0, FSM to IDLE, bvalid=rvalid=0, bresp=rresp=0, rdata=0, regs_o=0. awready, wready, arready are forced 0 while rst=1 and read 1 in the first cycle after rst falls.
- Reset mid-transaction discards latched AW/W and any pending B/R without completing them.
- Write latency: bvalid and the updated regs_o appear in the cycle after the last of the AW/W handshakes.
- Write throughput: at most one write per 2 cycles (bready=1 constant).
- Read latency: rvalid in the cycle after the AR handshake. Throughput is one read per 2 cycles.
- Same-edge write commit and AR capture to the same register: the read returns the pre-write value.
- bvalid and rvalid never drop without their ready. Payloads stay constant while valid=1 and ready=0.

## Configuration
- Macro: AXIDEMO_ADDR_ERR_EN.
- Defined: an out-of-range write updates nothing and returns bresp=2'b10. An out-of-range read returns rdata=0 with rresp=2'b10.
- Undefined: address bits above the index are ignored, so addresses alias modulo NUM_REGS*4. All responses are OKAY and the SLVERR encoding is never produced.

## Test plan
- Reset, then AW+W same cycle: awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF -> bvalid the next cycle, bresp=0, regs_o reg2=0xDEADBEEF. Then AR 0x08 -> rdata=0xDEADBEEF one cycle after the handshake.
- W first (wdata=0x11223344, wstrb=0x5), AW three cycles later (0x04), with reg1 previously 0xFFFFFFFF -> reg1=0xFF22FF44, and bvalid rises one cycle after the AW handshake.
- Hold bready=0 for 5 cycles while bvalid=1 -> awready=wready=0 throughout, bresp stable. Hold rready=0 with rvalid=1 -> arready=0, rdata stable.
- Same edge: write reg3=0xA5A5A5A5 (old value 0) and AR 0x0C -> rdata=0. A following read returns 0xA5A5A5A5.
- With AXIDEMO_ADDR_ERR_EN: write 0x40 (NUM_REGS=16) -> bresp=2'b10, regs unchanged. Read 0x40 -> rresp=2'b10, rdata=0. Without the macro: write 0x40 updates reg0 with OKAY.
- Assert rst in HAVE_AW and while rvalid=1 -> the next cycle shows bvalid=rvalid=0 and regs_o=0. The subsequent AW+W completes normally.
